// File: rtl/i2c_txn_sequencer.sv
// I2C register transaction sequencer: turns one register read or write
// request into the START / WR / RESTART / RD / STOP command stream for a
// byte-level I2C bit controller, collecting read bytes and slave NACK status.
// Bit-controller handshake: a command is issued only while i_ready=1, as a
// single-cycle o_wr_i2c pulse with o_cmd/o_din valid in that cycle; i_ready
// is ignored the cycle after the pulse, and the next i_ready=1 marks the
// command complete (i_ack/i_dout are evaluated in that cycle).
module i2c_txn_sequencer #(
  parameter int MAX_LEN = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_rw,
  input  logic [6:0]  i_dev_addr,
  input  logic [7:0]  i_reg_addr,
  input  logic [2:0]  i_len,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_wr_i2c,
  output logic [2:0]  o_cmd,
  output logic [7:0]  o_din,
  input  logic [7:0]  i_dout,
  input  logic        i_ack,
  input  logic        i_ready,
  output logic [5:0]  o_dbg_state
);

  localparam logic [2:0] CMD_START   = 3'b001;
  localparam logic [2:0] CMD_WR      = 3'b010;
  localparam logic [2:0] CMD_RD      = 3'b011;
  localparam logic [2:0] CMD_STOP    = 3'b100;
  localparam logic [2:0] CMD_RESTART = 3'b101;
  localparam logic [2:0] MAX_L       = 3'(MAX_LEN);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_REG, S_WDATA,
    S_RESTART, S_ADDR_R, S_RDATA, S_STOP, S_DONE
  } state_t;

  // ISSUE: waiting to send; WAIT1: blind cycle after the pulse; WAIT: completion
  typedef enum logic [1:0] {PH_ISSUE, PH_WAIT1, PH_WAIT} phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [2:0]  cmd_sel;
  logic [7:0]  din_sel;
  logic [2:0]  cnt_next;

  assign cnt_next    = cnt_q + 3'd1;
  assign o_rdata     = rdata_q;
  assign o_err       = err_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_dbg_state = {phase_q, state_q};

  // Command and data byte belonging to the current state
  always_comb begin
    cmd_sel = 3'd0;
    din_sel = 8'h00;
    case (state_q)
      S_START:   cmd_sel = CMD_START;
      S_ADDR_W:  begin cmd_sel = CMD_WR; din_sel = {dev_q, 1'b0}; end
      S_REG:     begin cmd_sel = CMD_WR; din_sel = reg_q; end
      S_WDATA:   begin cmd_sel = CMD_WR; din_sel = wdata_q[{cnt_q[1:0], 3'b000} +: 8]; end
      S_RESTART: cmd_sel = CMD_RESTART;
      S_ADDR_R:  begin cmd_sel = CMD_WR; din_sel = {dev_q, 1'b1}; end
      // NACK the final read byte so the slave releases the bus
      S_RDATA:   begin cmd_sel = CMD_RD; din_sel = (cnt_next == len_q) ? 8'h01 : 8'h00; end
      S_STOP:    cmd_sel = CMD_STOP;
      default:   ;
    endcase
  end

  // Next-state logic and bit-controller outputs
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    len_d    = len_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    o_wr_i2c = 1'b0;
    o_cmd    = 3'd0;
    o_din    = 8'h00;
    o_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          rw_d    = i_rw;
          dev_d   = i_dev_addr;
          reg_d   = i_reg_addr;
          len_d   = i_len;
          wdata_d = i_wdata;
          rdata_d = 32'h0;
          err_d   = 1'b0;
          cnt_d   = 3'd0;
          phase_d = PH_ISSUE;
          if (i_len == 3'd0 || i_len > MAX_L) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        case (phase_q)
          PH_ISSUE: begin
            if (i_ready) begin
              o_wr_i2c = 1'b1;
              o_cmd    = cmd_sel;
              o_din    = din_sel;
              phase_d  = PH_WAIT1;
            end
          end
          PH_WAIT1: phase_d = PH_WAIT;
          default: begin
            if (i_ready) begin
              phase_d = PH_ISSUE;
              case (state_q)
                S_START:   state_d = S_ADDR_W;
                S_ADDR_W:  begin
                  if (i_ack) begin err_d = 1'b1; state_d = S_STOP; end
                  else state_d = S_REG;
                end
                S_REG: begin
                  if (i_ack) begin err_d = 1'b1; state_d = S_STOP; end
                  else state_d = rw_q ? S_RESTART : S_WDATA;
                end
                S_WDATA: begin
                  if (i_ack) begin
                    err_d   = 1'b1;
                    state_d = S_STOP;
                  end else begin
                    cnt_d   = cnt_next;
                    state_d = (cnt_next == len_q) ? S_STOP : S_WDATA;
                  end
                end
                S_RESTART: state_d = S_ADDR_R;
                S_ADDR_R: begin
                  if (i_ack) begin err_d = 1'b1; state_d = S_STOP; end
                  else state_d = S_RDATA;
                end
                S_RDATA: begin
                  rdata_d[{cnt_q[1:0], 3'b000} +: 8] = i_dout;
                  cnt_d   = cnt_next;
                  state_d = (cnt_next == len_q) ? S_STOP : S_RDATA;
                end
                S_STOP:    state_d = S_DONE;
                default:   state_d = S_IDLE;
              endcase
            end
          end
        endcase
      end
    endcase
  end

  // State and request registers; reset abandons any transaction in flight
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      phase_q <= PH_ISSUE;
      cnt_q   <= 3'd0;
      rw_q    <= 1'b0;
      dev_q   <= 7'd0;
      reg_q   <= 8'd0;
      len_q   <= 3'd0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Self-checking bench for i2c_txn_sequencer with a behavioural bit-controller
// responder and a command-list reference model.
module tb_i2c_txn_sequencer;

  localparam int MAX_LEN = 4;
  localparam logic [2:0] C_START   = 3'b001;
  localparam logic [2:0] C_WR      = 3'b010;
  localparam logic [2:0] C_RD      = 3'b011;
  localparam logic [2:0] C_STOP    = 3'b100;
  localparam logic [2:0] C_RESTART = 3'b101;

  logic        clk;
  logic        i_reset, i_start, i_rw;
  logic [6:0]  i_dev_addr;
  logic [7:0]  i_reg_addr;
  logic [2:0]  i_len;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_busy, o_done, o_err, o_wr_i2c;
  logic [2:0]  o_cmd;
  logic [7:0]  o_din;
  logic [7:0]  i_dout;
  logic        i_ack, i_ready;
  logic [5:0]  o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];
  logic        exp_err;
  logic [31:0] exp_rdata;
  logic [7:0]  rd_bytes[4];
  int          nack_wr;
  int          wr_cnt, rd_cnt, done_cnt;
  bit          force_ready_low;
  int          ready_pct;

  i2c_txn_sequencer #(.MAX_LEN(MAX_LEN)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_rw(i_rw),
    .i_dev_addr(i_dev_addr), .i_reg_addr(i_reg_addr), .i_len(i_len),
    .i_wdata(i_wdata), .o_rdata(o_rdata), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_wr_i2c(o_wr_i2c), .o_cmd(o_cmd), .o_din(o_din),
    .i_dout(i_dout), .i_ack(i_ack), .i_ready(i_ready), .o_dbg_state(o_dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-controller readiness: random, or forced low for stall scenarios
  initial begin
    i_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (force_ready_low) i_ready = 1'b0;
      else i_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor and slave responder: records pulses, answers WR with ACK/NACK, RD with data
  initial begin
    i_ack  = 1'b0;
    i_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (!i_reset) begin
        if (o_wr_i2c) begin
          got_q.push_back({o_cmd, o_din});
          n_checks++;
          if (i_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pulse_without_ready: i_ready=%b required 1", i_ready);
          end
          if (o_cmd == C_WR) begin
            i_ack = (wr_cnt == nack_wr);
            wr_cnt++;
          end else if (o_cmd == C_RD) begin
            i_dout = rd_bytes[rd_cnt % 4];
            i_ack  = 1'($urandom_range(0, 1));
            rd_cnt++;
          end
        end else begin
          n_checks++;
          if (o_cmd !== 3'd0 || o_din !== 8'h00) begin
            n_fail++;
            $display("FAIL idle_cmd_din: cmd=%0h din=%0h required 0/0", o_cmd, o_din);
          end
        end
        if (o_done) done_cnt++;
      end
    end
  end

  // Reference model: full command list from the request, truncated at the NACKed WR
  task automatic build_model(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                             input logic [2:0] len, input logic [31:0] wd, input int nack);
    logic [10:0] seq[$];
    int wr_seen;
    int rdk;
    wr_seen = 0;
    rdk = 0;
    exp_q.delete();
    exp_err = 1'b0;
    exp_rdata = 32'h0;
    if (len == 3'd0 || int'(len) > MAX_LEN) begin
      exp_err = 1'b1;
      return;
    end
    seq.push_back({C_START, 8'h00});
    seq.push_back({C_WR, dev, 1'b0});
    seq.push_back({C_WR, rg});
    if (!rw) begin
      for (int k = 0; k < int'(len); k++) seq.push_back({C_WR, wd[8*k +: 8]});
    end else begin
      seq.push_back({C_RESTART, 8'h00});
      seq.push_back({C_WR, dev, 1'b1});
      for (int k = 0; k < int'(len); k++)
        seq.push_back({C_RD, (k == int'(len) - 1) ? 8'h01 : 8'h00});
    end
    for (int i = 0; i < seq.size(); i++) begin
      exp_q.push_back(seq[i]);
      if (seq[i][10:8] == C_WR) begin
        if (wr_seen == nack) begin
          exp_err = 1'b1;
          break;
        end
        wr_seen++;
      end else if (seq[i][10:8] == C_RD) begin
        exp_rdata[8*rdk +: 8] = rd_bytes[rdk];
        rdk++;
      end
    end
    exp_q.push_back({C_STOP, 8'h00});
  endtask

  // Driver: compute expectations, clear monitor state, present request inputs
  task automatic prepare(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [2:0] len, input logic [31:0] wd, input int nack);
    build_model(rw, dev, rg, len, wd, nack);
    got_q.delete();
    wr_cnt = 0;
    rd_cnt = 0;
    done_cnt = 0;
    nack_wr = nack;
    i_rw = rw;
    i_dev_addr = dev;
    i_reg_addr = rg;
    i_len = len;
    i_wdata = wd;
  endtask

  // Wait for o_done (bounded) and compare everything against the model
  task automatic wait_check(input string name, input bit bad_len);
    int cycles;
    bit to;
    cycles = 0;
    to = 1'b0;
    forever begin
      @(negedge clk);
      if (o_done === 1'b1) break;
      n_checks++;
      if (o_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy: o_busy=%b required 1", name, o_busy);
      end
      cycles++;
      if (cycles > 4000) begin to = 1'b1; break; end
    end
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL %s timeout: no o_done after %0d cycles required done", name, cycles);
    end
    if (bad_len) begin
      n_checks++;
      if (cycles != 0) begin
        n_fail++;
        $display("FAIL %s done_latency: %0d extra cycles required 0", name, cycles);
      end
    end
    n_checks++;
    if (o_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s err: o_err=%b required %b", name, o_err, exp_err);
    end
    n_checks++;
    if (o_rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL %s rdata: o_rdata=%h required %h", name, o_rdata, exp_rdata);
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s cmd_count: %0d pulses required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size()) begin
        n_fail++;
        $display("FAIL %s cmd[%0d]: missing required %h", name, i, exp_q[i]);
      end else if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cmd[%0d]: {cmd,din}=%h required %h", name, i, got_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: done=%b busy=%b required 0/0", name, o_done, o_busy);
    end
    n_checks++;
    if (o_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s err_hold: o_err=%b required %b", name, o_err, exp_err);
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL %s done_pulses: %0d required 1", name, done_cnt);
    end
  endtask

  // One complete transaction with a single-cycle start pulse
  task automatic run_txn(input string name, input logic rw, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [2:0] len, input logic [31:0] wd,
                         input int nack);
    @(posedge clk);
    #1;
    prepare(rw, dev, rg, len, wd, nack);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_rw = 1'($urandom_range(0, 1));
    i_dev_addr = 7'($urandom);
    i_reg_addr = 8'($urandom);
    i_len = 3'($urandom);
    i_wdata = $urandom;
    wait_check(name, (len == 3'd0 || int'(len) > MAX_LEN));
  endtask

  task automatic test_reset;
    i_reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b done=%b err=%b required 0", o_busy, o_done, o_err);
    end
    n_checks++;
    if (o_rdata !== 32'h0 || o_wr_i2c !== 1'b0 || o_cmd !== 3'd0 || o_din !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_bus: rdata=%h wr=%b cmd=%h din=%h required 0", o_rdata, o_wr_i2c, o_cmd, o_din);
    end
    @(posedge clk);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic test_write;
    run_txn("write", 1'b0, 7'h50, 8'h10, 3'd2, 32'h0000BBAA, -1);
  endtask

  task automatic test_read;
    rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;
    run_txn("read", 1'b1, 7'h50, 8'h20, 3'd3, 32'h0, -1);
  endtask

  task automatic test_addr_nack;
    run_txn("addr_nack", 1'b0, 7'h50, 8'h30, 3'd2, 32'h00001234, 0);
    run_txn("data_nack", 1'b0, 7'h2A, 8'h31, 3'd4, 32'hDEADBEEF, 3);
  endtask

  task automatic test_bad_len;
    run_txn("len0", 1'b0, 7'h50, 8'h10, 3'd0, 32'h12345678, -1);
    run_txn("len5", 1'b1, 7'h50, 8'h10, 3'd5, 32'h12345678, -1);
  endtask

  task automatic test_reset_mid_read;
    int guard;
    guard = 0;
    rd_bytes[0] = 8'h5A; rd_bytes[1] = 8'hC3; rd_bytes[2] = 8'h7E; rd_bytes[3] = 8'h01;
    @(posedge clk);
    #1;
    prepare(1'b1, 7'h50, 8'h20, 3'd3, 32'h0, -1);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    while (rd_cnt < 2 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (rd_cnt < 2) begin
      n_fail++;
      $display("FAIL reset_mid_read reach_rd: rd pulses=%0d required 2", rd_cnt);
    end
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0 || o_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_read status: busy=%b done=%b err=%b rdata=%h required 0",
               o_busy, o_done, o_err, o_rdata);
    end
    n_checks++;
    if (o_wr_i2c !== 1'b0 || o_cmd !== 3'd0 || o_din !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_read bus: wr=%b cmd=%h din=%h required 0", o_wr_i2c, o_cmd, o_din);
    end
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    run_txn("read_after_reset", 1'b1, 7'h50, 8'h20, 3'd3, 32'h0, -1);
  endtask

  task automatic test_held_start_stall;
    @(posedge clk);
    #1;
    prepare(1'b0, 7'h3C, 8'h44, 3'd1, 32'h000000E7, -1);
    force_ready_low = 1'b1;
    i_start = 1'b1;
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      n_checks++;
      if (got_q.size() != 0 || o_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall: pulses=%0d busy=%b required 0/1", got_q.size(), o_busy);
      end
    end
    force_ready_low = 1'b0;
    wait_check("held_first", 1'b0);
    got_q.delete();
    wr_cnt = 0;
    rd_cnt = 0;
    done_cnt = 0;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL held_restart: o_busy=%b required 1", o_busy);
    end
    wait_check("held_second", 1'b0);
  endtask

  task automatic test_random;
    logic       rw;
    logic [2:0] len;
    int         nack;
    int         n_wr;
    for (int t = 0; t < 12; t++) begin
      rw = 1'($urandom_range(0, 1));
      len = 3'($urandom_range(0, 6));
      n_wr = rw ? 3 : 2 + int'(len);
      nack = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n_wr - 1) : -1;
      ready_pct = $urandom_range(30, 100);
      for (int k = 0; k < 4; k++) rd_bytes[k] = 8'($urandom);
      run_txn("random", rw, 7'($urandom), 8'($urandom), len, $urandom, nack);
    end
    ready_pct = 75;
  endtask

  // Test sequence and final report
  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    i_rw = 1'b0;
    i_dev_addr = 7'h0;
    i_reg_addr = 8'h0;
    i_len = 3'd0;
    i_wdata = 32'h0;
    ready_pct = 75;
    force_ready_low = 1'b0;
    nack_wr = -1;
    wr_cnt = 0;
    rd_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 4; k++) rd_bytes[k] = 8'h00;
    test_reset;
    test_write;
    test_read;
    test_addr_nack;
    test_bad_len;
    test_reset_mid_read;
    test_held_start_stall;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
